// File: rtl/cis_pkg.sv
// Shared definitions for the capture writer and the display reader.
package cis_pkg;

  localparam int unsigned IN_W      = 640;
  localparam int unsigned IN_H      = 480;
  localparam int unsigned OUT_W     = 320;
  localparam int unsigned OUT_H     = 240;
  localparam int unsigned FB_ADDR_W = 17;
  localparam int unsigned PIX_W     = 12;
  localparam int unsigned CH_W      = 4;

  // RGB444 byte-field positions: byte0 = {xxxx,R}, byte1 = {G,B}
  localparam int unsigned B0_R_LSB  = 0;
  localparam int unsigned B1_G_LSB  = 4;
  localparam int unsigned B1_B_LSB  = 0;

  typedef enum logic [1:0] {
    ST_SYNC   = 2'd0,
    ST_VBLANK = 2'd1,
    ST_ACTIVE = 2'd2
  } cap_state_e;

  typedef struct packed {
    logic [CH_W-1:0] r;
    logic [CH_W-1:0] g;
    logic [CH_W-1:0] b;
  } rgb444_t;

endpackage

// File: rtl/cis_capture_writer_packer.sv
// Assembles two sensor bytes into one RGB444 pixel.
module rgb444_pixel_packer
  import cis_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       href,
  input  logic [7:0] data,
  output logic       pixel_valid_c,
  output rgb444_t    pixel_c
);

  logic            phase_q, phase_d;
  logic [CH_W-1:0] r_q, r_d;

  // Phase toggles on each href-high byte; held at 0 while href is low so every line starts at byte0
  always_comb begin
    phase_d = 1'b0;
    r_d     = r_q;
    if (href) begin
      phase_d = ~phase_q;
      if (!phase_q) begin
        r_d = data[B0_R_LSB +: CH_W];
      end
    end
  end

  // Phase and red-channel registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q <= 1'b0;
      r_q     <= '0;
    end else begin
      phase_q <= phase_d;
      r_q     <= r_d;
    end
  end

  // Pixel completes on the byte1 cycle
  always_comb begin
    pixel_valid_c = href & phase_q;
    pixel_c.r     = r_q;
    pixel_c.g     = data[B1_G_LSB +: CH_W];
    pixel_c.b     = data[B1_B_LSB +: CH_W];
  end

endmodule

// File: rtl/cis_capture_writer.sv
// Captures a sensor RGB444 stream, decimates 2:1 in x and y, writes the frame buffer.
module cis_capture_writer
  import cis_pkg::*;
#(
  parameter int unsigned P_IN_W = IN_W,
  parameter int unsigned P_IN_H = IN_H
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 capture_en,
  input  logic                 cam_vsync,
  input  logic                 cam_href,
  input  logic [7:0]           cam_data,
  output logic                 wr_en,
  output logic [FB_ADDR_W-1:0] wr_addr,
  output logic [PIX_W-1:0]     wr_data,
  output logic                 frame_done,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int unsigned PW = $clog2(P_IN_W + 1);
  localparam int unsigned LW = $clog2(P_IN_H + 2);
  localparam logic [PW-1:0] PIX_MAX  = PW'(P_IN_W);
  localparam logic [LW-1:0] LINE_END = LW'(P_IN_H);
  localparam logic [LW-1:0] LINE_MAX = LW'(P_IN_H + 1);

  cap_state_e           state_q, state_d;
  logic                 vs_q, vs_d, vs_d1_q, vs_d1_d;
  logic                 hr_q, hr_d, hr_d1_q, hr_d1_d;
  logic [7:0]           dat_q, dat_d;
  logic [PW-1:0]        pix_cnt_q, pix_cnt_d;
  logic [LW-1:0]        line_cnt_q, line_cnt_d;
  logic                 wr_en_q, wr_en_d;
  logic [FB_ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [PIX_W-1:0]     wr_data_q, wr_data_d;
  logic                 done_q, done_d, err_q, err_d, busy_q, busy_d;

  logic                 vs_rise_c, vs_fall_c, hr_fall_c;
  logic                 pixel_valid_c;
  rgb444_t              pixel_c;
  logic [FB_ADDR_W-1:0] row_c, col_c, addr_c;

  rgb444_pixel_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .href         (hr_q),
    .data         (dat_q),
    .pixel_valid_c(pixel_valid_c),
    .pixel_c      (pixel_c)
  );

  // Edge detection on registered sensor timing, and row*320 + col as shift-add
  always_comb begin
    vs_rise_c = vs_q & ~vs_d1_q;
    vs_fall_c = ~vs_q & vs_d1_q;
    hr_fall_c = ~hr_q & hr_d1_q;
    row_c     = FB_ADDR_W'(line_cnt_q >> 1);
    col_c     = FB_ADDR_W'(pix_cnt_q >> 1);
    addr_c    = (row_c << 8) + (row_c << 6) + col_c;
  end

  // Next-state: input pipeline, counters, decimated write, frame FSM
  always_comb begin
    vs_d       = cam_vsync;
    hr_d       = cam_href;
    dat_d      = cam_data;
    vs_d1_d    = vs_q;
    hr_d1_d    = hr_q;
    state_d    = state_q;
    pix_cnt_d  = pix_cnt_q;
    line_cnt_d = line_cnt_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    if (hr_fall_c) begin
      pix_cnt_d = '0;
      if (line_cnt_q != LINE_MAX) line_cnt_d = line_cnt_q + LW'(1);
    end else if (pixel_valid_c && pix_cnt_q != PIX_MAX) begin
      pix_cnt_d = pix_cnt_q + PW'(1);
    end

    if (pixel_valid_c && state_q == ST_ACTIVE && pix_cnt_q < PIX_MAX &&
        line_cnt_q < LINE_END && !pix_cnt_q[0] && !line_cnt_q[0]) begin
      wr_en_d   = 1'b1;
      wr_addr_d = addr_c;
      wr_data_d = pixel_c;
    end

    case (state_q)
      ST_SYNC: begin
        if (vs_q) state_d = ST_VBLANK;
      end
      ST_VBLANK: begin
        line_cnt_d = '0;
        if (vs_fall_c) state_d = capture_en ? ST_ACTIVE : ST_SYNC;
      end
      ST_ACTIVE: begin
        if (vs_rise_c) begin
          if (line_cnt_q == LINE_END) done_d = 1'b1;
          else                        err_d  = 1'b1;
          state_d = ST_VBLANK;
        end
      end
      default: state_d = ST_SYNC;
    endcase

    busy_d = (state_d == ST_ACTIVE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_SYNC;
      vs_q       <= 1'b0;
      vs_d1_q    <= 1'b0;
      hr_q       <= 1'b0;
      hr_d1_q    <= 1'b0;
      dat_q      <= '0;
      pix_cnt_q  <= '0;
      line_cnt_q <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      vs_q       <= vs_d;
      vs_d1_q    <= vs_d1_d;
      hr_q       <= hr_d;
      hr_d1_q    <= hr_d1_d;
      dat_q      <= dat_d;
      pix_cnt_q  <= pix_cnt_d;
      line_cnt_q <= line_cnt_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      done_q     <= done_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign frame_done = done_q;
  assign frame_err  = err_q;
  assign busy       = busy_q;

endmodule

// File: doc/cis_capture_writer.md
# cis_capture_writer

Writes a CMOS image sensor's pixel stream into the 320x240 RGB444 SRAM frame buffer. The video timing generator later reads that buffer and upscales it to 640x480 HDMI. The block receives a 640x480 RGB444 byte stream (two bytes per pixel, frame/line framed by vsync/href) and decimates it 2:1 in both axes. It then issues one SRAM write per kept pixel at the same address map the display reader uses: addr = y*320 + x.

## Interface
- IN_W, 640, sensor active pixels per line
- IN_H, 480, sensor active lines per frame
- OUT_W, 320, frame-buffer width (IN_W/2)
- clk  in  1  sensor pixel clock; all inputs synchronous to it
- rst  in  1  reset; asynchronous, active-low (0 = reset)
- capture_en  in  1  capture enable, sampled only at frame start
- cam_vsync  in  1  frame sync, high during vertical blanking
- cam_href  in  1  line valid, high while bytes of one line are present
- cam_data  in  8  pixel byte; byte0 = {xxxx,R[3:0]}, byte1 = {G[3:0],B[3:0]}
- wr_en  out  1  one-cycle SRAM write strobe
- wr_addr  out  17  SRAM write address, 0..76799
- wr_data  out  12  {R,G,B} 4 bits each
- frame_done  out  1  one-cycle pulse: complete frame written
- frame_err  out  1  one-cycle pulse: frame ended with line count != IN_H
- busy  out  1  high while state = ACTIVE

## Operation
- cam_vsync, cam_href and cam_data are registered once on input; all edge detection uses the registered copies.
- States:
  - SYNC: after reset, wait for vsync = 1, then go to VBLANK. This discards any partial frame.
  - VBLANK: on the vsync falling edge, go to ACTIVE if capture_en = 1, else go to SYNC. Clear line_cnt.
  - ACTIVE: capture. On the vsync rising edge:
    - line_cnt == IN_H: pulse frame_done.
    - otherwise: pulse frame_err.
    - Either way, go to VBLANK.
- Byte phase: toggles on every href-high cycle and is cleared at the href rising edge.
  - Phase 0 latches R.
  - Phase 1 completes a pixel and increments pix_cnt (0..IN_W-1, saturates at IN_W).
- Line end: at the href falling edge, line_cnt increments (saturates at IN_H+1). A partial pixel left in phase 1 is discarded.
- Write rule: a pixel is written only when all of the following hold:
  - state = ACTIVE
  - pix_cnt < IN_W
  - line_cnt < IN_H
  - pix_cnt[0] = 0
  - line_cnt[0] = 0
- Write data and address:
  - wr_addr = (line_cnt>>1)*OUT_W + (pix_cnt>>1), computed as shift-add (l<<8)+(l<<6)+p, 17-bit, no overflow possible.
  - wr_data = {byte0[3:0], byte1[7:0]}.
- Pixels beyond IN_W and lines beyond IN_H are dropped silently, with no writes. An overlong frame gives frame_err at its end.
- vsync rising mid-line: abort the line (no further writes) and apply the end-of-frame rule above.
- capture_en deasserted mid-frame has no effect until the next frame start.

## Timing
- Reset values: wr_en = 0, wr_addr = 0, wr_data = 0, frame_done = 0, frame_err = 0, busy = 0; state = SYNC; all counters 0.
- Asynchronous reset clears everything immediately. An in-flight write is dropped, never completed.
- Write latency: bytes on cam_data in cycles k, k+1 produce wr_en = 1 with valid wr_addr/wr_data in cycle k+3, for exactly one cycle.
  - Successive writes are at least 4 cycles apart, because every other pixel is dropped.
- frame_done / frame_err are high in cycle v+2, where v is the cycle cam_vsync first goes high.
  - They are never both high.
  - Any pending last write is issued no later than the same cycle.
- busy rises in cycle f+2 after the vsync fall seen in cycle f; it falls together with the frame_done/err pulse.
- No backpressure: the SRAM port must accept a write every cycle wr_en is high.

## Structure
- Shared package cis_pkg:
  - IN_W, IN_H, OUT_W, OUT_H localparams
  - FB_ADDR_W = 17
  - State encoding SYNC/VBLANK/ACTIVE
  - The RGB444 byte-field positions, so the display reader and this writer share the map.
- Sub-module rgb444_pixel_packer: byte-phase toggle, byte0 latch, and a one-cycle pixel_valid with 12-bit pixel. The top keeps the FSM, counters, decimation and address generation.

## Test plan
- Reset held low, then released with vsync low and href toggling: no wr_en and busy = 0 until a full vsync high→low cycle has been seen.
- One full 640x480 frame with pixel (x,y) bytes encoding R = x[3:0], G = y[3:0], B = x[7:4] → exactly 76800 writes.
  - Line 2, pixel 6 writes addr 323 with data {6,2,0}.
  - frame_done pulses once; frame_err stays 0.
- Frame with only 479 lines, then vsync rises → frame_err one pulse, frame_done 0, then normal capture of the next frame.
- Line with 700 pixels and an odd final byte → 320 writes on that line, last addr y*320+319, no write from the trailing byte.
- capture_en = 0 at the vsync falling edge, raised mid-frame → no writes for that frame; capture starts at the following frame.
- rst asserted low mid-line during a pending write → wr_en 0 immediately; after release, the block waits in SYNC.
